// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared defaults and state encoding for the HI/LO multiply
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_MUL_LAT = 17;
    localparam int DEF_CNT_W   = 5;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_START   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_CAPTURE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = S_IDLE,
        ST_START   = S_START,
        ST_WAIT    = S_WAIT,
        ST_CAPTURE = S_CAPTURE
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mult_hilo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_hilo_ctrl_if
// Description : CPU request, multiplier and HI/LO bundle for mult_hilo_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface mult_hilo_ctrl_if #(
    parameter int DATA_W = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic [DATA_W-1:0]     op_a;
    logic [DATA_W-1:0]     op_b;
    logic                  mul_st;
    logic [DATA_W-1:0]     mul_m1;
    logic [DATA_W-1:0]     mul_m2;
    logic [2*DATA_W-1:0]   mul_resul;
    logic                  wr_hi;
    logic                  wr_lo;
    logic [DATA_W-1:0]     wr_data;
    logic [DATA_W-1:0]     hi;
    logic [DATA_W-1:0]     lo;
    logic                  busy;
    logic                  done;

    // Controller side
    modport slave (
        input  req_valid, op_a, op_b, mul_resul, wr_hi, wr_lo, wr_data,
        output req_ready, mul_st, mul_m1, mul_m2, hi, lo, busy, done
    );

    // CPU datapath and multiplier side
    modport master (
        output req_valid, op_a, op_b, mul_resul, wr_hi, wr_lo, wr_data,
        input  req_ready, mul_st, mul_m1, mul_m2, hi, lo, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/lat_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : lat_down_counter
// Description : Loadable down-counter with enable and zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module lat_down_counter #(
    parameter int CNT_W = 5
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic [CNT_W-1:0] i_load_val,
    input  wire logic             i_en,
    output logic                  o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/mult_hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mult_hilo_ctrl
// Description : Sequences a fixed-latency multiplier and owns the HI/LO regs.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_hilo_ctrl
    import mult_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  wire logic       clk,
    input  wire logic       rst,
    mult_hilo_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] C_LOAD = CNT_W'(MUL_LAT - 1);

    state_t              r_state;
    state_t              w_next;
    logic                w_load;
    logic                w_en;
    logic                w_zero;
    logic                w_accept;
    logic [DATA_W-1:0]   r_m1;
    logic [DATA_W-1:0]   r_m2;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic                r_done;

    lat_down_counter #(
        .CNT_W (CNT_W)
    ) u_lat_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (C_LOAD),
        .i_en       (w_en),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_en   = 1'b0;
        case (r_state)
            ST_IDLE:    if (bus.req_valid) w_next = ST_START;
            ST_START: begin
                w_load = 1'b1;
                w_next = ST_WAIT;
            end
            ST_WAIT: begin
                w_en = 1'b1;
                if (w_zero) w_next = ST_CAPTURE;
            end
            ST_CAPTURE: w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    assign w_accept = (r_state == ST_IDLE) && bus.req_valid;

    // mthi/mtlo are honoured only in IDLE; a product capture always wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m1   <= '0;
            r_m2   <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == ST_CAPTURE);
            if (w_accept) begin
                r_m1 <= bus.op_a;
                r_m2 <= bus.op_b;
            end
            if (r_state == ST_CAPTURE) begin
                r_hi <= bus.mul_resul[2*DATA_W-1:DATA_W];
                r_lo <= bus.mul_resul[DATA_W-1:0];
            end else if (r_state == ST_IDLE) begin
                if (bus.wr_hi) r_hi <= bus.wr_data;
                if (bus.wr_lo) r_lo <= bus.wr_data;
            end
        end
    end

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.mul_st    = (r_state == ST_START);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.mul_m1    = r_m1;
    assign bus.mul_m2    = r_m2;
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;
    assign bus.done      = r_done;

endmodule
`default_nettype wire
